// File: rtl/bus6502_pkg.sv
// bus6502_pkg -- shared definitions for the 6502 bus arbiter.
//
// Contents:
//   arb_state_t        arbiter FSM state encoding (S_CPU, S_DMA, S_RESUME)
//   DMA_BURST_DEFAULT  default maximum DMA accesses per grant
//   BURST_W            width of the burst counter (holds 1..255)
//
// Configuration macro: ARB_BURST_LIMIT_EN (consumed by the arbiter and the
// burst counter, not by this package).
package bus6502_pkg;

    typedef enum logic [1:0] {
        S_CPU    = 2'd0,  // CPU owns the bus
        S_DMA    = 2'd1,  // secondary master owns the bus, CPU stalled
        S_RESUME = 2'd2   // CPU address re-presented, read data in flight
    } arb_state_t;

    localparam int DMA_BURST_DEFAULT = 16;
    localparam int BURST_W           = 8;

endpackage

// File: rtl/arb_burst_ctr.sv
// arb_burst_ctr -- counts DMA accesses within one grant.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high
//   clear      in   restart counting (asserted on entry to S_DMA)
//   enable     in   one DMA access is being issued this cycle
//   limit_hit  out  the access issued this cycle is number LIMIT (or later)
//
// The counter saturates at its all-ones value instead of wrapping.
// Configuration macro: ARB_BURST_LIMIT_EN -- the module only exists when
// burst limiting is built in, so the default build carries no counter.
`ifdef ARB_BURST_LIMIT_EN
module arb_burst_ctr
    import bus6502_pkg::*;
#(
    parameter int LIMIT = DMA_BURST_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);

    localparam logic [BURST_W-1:0] LIMIT_M1 = BURST_W'(LIMIT - 1);
    localparam logic [BURST_W-1:0] CNT_MAX  = '1;

    logic [BURST_W-1:0] count;

    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of accesses already completed in this grant,
    // so the access issued now is number count+1.
    assign limit_hit = enable && (count >= LIMIT_M1);

endmodule
`endif

// File: rtl/bus_arbiter_6502.sv
// bus_arbiter_6502 -- shares one memory bus between a 6502 CPU and a
// secondary master (loader/DMA). The CPU is stalled through RDY while the
// DMA owns the bus, and its held read address is re-presented for one cycle
// before RDY returns so the registered memory delivers the right byte.
//
// Ports:
//   clk, reset                    clock (rising edge), sync active-high reset
//   cpu_ab/cpu_do/cpu_we          CPU address, write data, write enable
//   cpu_di, cpu_rdy               CPU read data, CPU ready (low = stall)
//   dma_req                       DMA request, level-held
//   dma_ab/dma_do/dma_we          DMA address, write data, write enable
//   dma_gnt                       DMA owns the bus this cycle
//   dma_ack, dma_di               previous DMA access done, its read data
//   mem_ab/mem_do/mem_we, mem_di  shared memory bus (mem_di one cycle late)
//
// Configuration macro: ARB_BURST_LIMIT_EN -- when defined, a grant ends after
// DMA_BURST accesses and the CPU gets at least one cycle before the next
// grant; when undefined the DMA keeps the bus until it drops dma_req.
module bus_arbiter_6502
    import bus6502_pkg::*;
#(
    parameter int DMA_BURST = DMA_BURST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_we,
    output logic [7:0]  cpu_di,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic [15:0] dma_ab,
    input  logic [7:0]  dma_do,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_di,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    input  logic [7:0]  mem_di
);

    arb_state_t state;

    logic start_dma;   // grant at this edge: only while the CPU is reading
    logic access;      // a DMA access is issued this cycle
    logic burst_done;  // the access issued this cycle ends the grant

    assign start_dma = (state == S_CPU) && dma_req && !cpu_we;
    assign access    = (state == S_DMA) && dma_req;

`ifdef ARB_BURST_LIMIT_EN
    arb_burst_ctr #(
        .LIMIT(DMA_BURST)
    ) u_burst_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_dma),
        .enable   (access),
        .limit_hit(burst_done)
    );
`else
    // No burst limit: for any legal DMA_BURST (1..255) this folds to 0.
    assign burst_done = (DMA_BURST == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_CPU;
            cpu_rdy <= 1'b1;
            dma_gnt <= 1'b0;
            dma_ack <= 1'b0;
        end else begin
            dma_ack <= access;
            case (state)
                S_CPU: begin
                    if (start_dma) begin
                        state   <= S_DMA;
                        cpu_rdy <= 1'b0;
                        dma_gnt <= 1'b1;
                    end
                end
                S_DMA: begin
                    if (!dma_req || burst_done) begin
                        state   <= S_RESUME;
                        dma_gnt <= 1'b0;
                    end
                end
                S_RESUME: begin
                    state   <= S_CPU;
                    cpu_rdy <= 1'b1;
                end
                default: begin
                    state   <= S_CPU;
                    cpu_rdy <= 1'b1;
                    dma_gnt <= 1'b0;
                end
            endcase
        end
    end

    // Bus steering. S_RESUME presents the CPU's held read address again.
    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        mem_ab = cpu_ab;
        mem_do = cpu_do;
        mem_we = cpu_we;
        if (state == S_DMA) begin
            mem_ab = dma_ab;
            mem_do = dma_do;
            mem_we = dma_we && dma_req;  // no write once the request is gone
        end
    end

    // Memory data is registered, so both masters simply watch mem_di; each
    // qualifies it with its own strobe (cpu_rdy, dma_ack).
    assign cpu_di = mem_di;
    assign dma_di = mem_di;

endmodule

// File: tb/tb_bus_arbiter_6502.sv
// tb_bus_arbiter_6502 -- self-checking bench for bus_arbiter_6502.
// Uses DMA_BURST=4; burst-limit expectations follow ARB_BURST_LIMIT_EN.
module tb_bus_arbiter_6502;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;
    logic        cpu_rdy;
    logic        dma_req;
    logic [15:0] dma_ab;
    logic [7:0]  dma_do;
    logic        dma_we;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_di;
    logic [15:0] mem_ab;
    logic [7:0]  mem_do;
    logic        mem_we;
    logic [7:0]  mem_di;

    bus_arbiter_6502 #(.DMA_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_ab(dma_ab), .dma_do(dma_do), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_di(dma_di),
        .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
    );

    always #5 clk = ~clk;

    // Memory model: RAM below $8000, fixed ROM bytes above, registered read.
    logic [7:0] ram [0:32767];

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'hAA00: rom = 8'hA9;
            16'hFFFC: rom = 8'h00;
            16'hFFFD: rom = 8'hAA;
            16'hFFFE: rom = 8'h5A;
            default:  rom = 8'hEA;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_we && !mem_ab[15]) ram[mem_ab[14:0]] <= mem_do;
        mem_di <= mem_ab[15] ? rom(mem_ab) : ram[mem_ab[14:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Registered outputs settle at the edge; inputs are driven at +1,
    // outputs are checked at +2.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Scoreboards: expected DMA read bytes and expected DMA writes.
    logic [7:0] rd_q [$];
    typedef struct packed {
        logic [15:0] ab;
        logic [7:0]  d;
    } wr_t;
    wr_t wr_q [$];
    int  n_ack = 0;

    task automatic ack_check;
        if (dma_ack) begin
            n_ack++;
            if (rd_q.size() == 0) begin
                check("ack_unexpected", 32'(dma_ack), 32'd0);
            end else begin
                check("dma_di", 32'(dma_di), 32'(rd_q.pop_front()));
            end
        end
    endtask

    typedef struct {
        logic [15:0] ab;
        logic [7:0]  d;
        logic        we;
        logic        req;
        logic        exp_gnt;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rd_addr [3];
        logic [7:0]  rd_exp  [3];
        logic        eg, er, prev_acc, reached;
        int          n, writes, exp_writes;
        wr_t         w;

        // Passthrough vectors; the last one is a read with a pending request,
        // which is the request cycle of the following DMA read sequence.
        vecs[0] = '{16'hAA00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{16'h0300, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h4000, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h4000, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'hAA00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

        rd_addr[0] = 16'hFFFC; rd_exp[0] = 8'h00;
        rd_addr[1] = 16'hFFFD; rd_exp[1] = 8'hAA;
        rd_addr[2] = 16'hFFFE; rd_exp[2] = 8'h5A;

        reset = 1'b1;
        cpu_ab = 16'h0000; cpu_do = 8'h00; cpu_we = 1'b0;
        dma_req = 1'b0; dma_ab = 16'h0000; dma_do = 8'h00; dma_we = 1'b0;
        tick; tick; settle;
        check("reset_rdy", 32'(cpu_rdy), 32'd1);
        check("reset_gnt", 32'(dma_gnt), 32'd0);
        check("reset_ack", 32'(dma_ack), 32'd0);
        reset = 1'b0;

        // CPU passthrough, including a write with a DMA request pending.
        for (int i = 0; i < 5; i++) begin
            tick;
            cpu_ab = vecs[i].ab; cpu_do = vecs[i].d; cpu_we = vecs[i].we;
            dma_req = vecs[i].req; dma_ab = 16'hFFFC; dma_we = 1'b0;
            settle;
            check("vec_mem_ab", 32'(mem_ab), 32'(vecs[i].ab));
            check("vec_mem_do", 32'(mem_do), 32'(vecs[i].d));
            check("vec_mem_we", 32'(mem_we), 32'(vecs[i].we));
            check("vec_gnt",    32'(dma_gnt), 32'(vecs[i].exp_gnt));
            check("vec_rdy",    32'(cpu_rdy), 32'(vecs[i].exp_rdy));
        end

        // Three DMA reads of the vector area while the CPU holds a read.
        for (int k = 0; k < 3; k++) begin
            tick;
            dma_ab = rd_addr[k];
            rd_q.push_back(rd_exp[k]);
            settle;
            check("rd_gnt",    32'(dma_gnt), 32'd1);
            check("rd_rdy",    32'(cpu_rdy), 32'd0);
            check("rd_mem_ab", 32'(mem_ab), 32'(rd_addr[k]));
            check("rd_mem_we", 32'(mem_we), 32'd0);
            ack_check;
        end
        tick;
        dma_req = 1'b0;
        settle;
        check("rd_tail_gnt", 32'(dma_gnt), 32'd1);
        check("rd_tail_we",  32'(mem_we), 32'd0);
        ack_check;
        tick; settle;
        check("resume_rdy",  32'(cpu_rdy), 32'd0);
        check("resume_gnt",  32'(dma_gnt), 32'd0);
        check("resume_ab",   32'(mem_ab), 32'hAA00);
        check("resume_ack",  32'(dma_ack), 32'd0);
        tick; settle;
        check("cpu_back_rdy", 32'(cpu_rdy), 32'd1);
        check("cpu_back_di",  32'(cpu_di), 32'hA9);
        check("rd_ack_count", 32'(n_ack), 32'd3);
        check("rd_q_empty",   32'(rd_q.size()), 32'd0);
        check("sta_4000",     32'(ram[15'h4000]), 32'h5C);

        // Reset during the third access of a grant.
        tick;
        dma_req = 1'b1; dma_ab = 16'h0010; dma_we = 1'b0;
        tick; tick; tick;
        reset = 1'b1;
        settle;
        check("rst_mid_gnt", 32'(dma_gnt), 32'd1);
        tick;
        reset = 1'b0; dma_req = 1'b0;
        settle;
        check("rst_mid_rdy", 32'(cpu_rdy), 32'd1);
        check("rst_mid_gnt_after", 32'(dma_gnt), 32'd0);
        check("rst_mid_ack", 32'(dma_ack), 32'd0);
        tick; settle;
        check("rst_mid_ack2", 32'(dma_ack), 32'd0);
        check("rst_mid_gnt2", 32'(dma_gnt), 32'd0);

        // Held request, DMA writes from $0200 upward.
        for (int i = 0; i < 16; i++) begin
            w.ab = 16'(16'h0200 + i);
            w.d  = 8'(8'h30 + i);
            wr_q.push_back(w);
        end
        n = 0; prev_acc = 1'b0; writes = 0; exp_writes = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            if (prev_acc) n++;
            dma_req = 1'b1; dma_we = 1'b1;
            dma_ab = 16'(16'h0200 + n);
            dma_do = 8'(8'h30 + n);
            settle;
`ifdef ARB_BURST_LIMIT_EN
            eg = (c >= 1) && (((c - 1) % 6) < 4);
            er = (c == 0) || (((c - 1) % 6) == 5);
`else
            eg = (c >= 1);
            er = (c == 0);
`endif
            check("burst_gnt", 32'(dma_gnt), 32'(eg));
            check("burst_rdy", 32'(cpu_rdy), 32'(er));
            if (eg) exp_writes++;
            if (dma_gnt && mem_we) begin
                writes++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'(mem_we), 32'd0);
                end else begin
                    w = wr_q.pop_front();
                    check("wr_ab", 32'(mem_ab), 32'(w.ab));
                    check("wr_do", 32'(mem_do), 32'(w.d));
                end
            end
            prev_acc = dma_gnt && dma_req;
        end

        // Request drops with dma_we still high: no further write.
        tick;
        dma_req = 1'b0;
        settle;
        check("drop_gnt", 32'(dma_gnt), 32'd1);
        check("drop_we",  32'(mem_we), 32'd0);
        reached = 1'b0;
        for (int t = 0; t < 4 && !reached; t++) begin
            tick; settle;
            check("drain_we", 32'(mem_we), 32'd0);
            reached = cpu_rdy;
        end
        check("drain_rdy_timeout", 32'(reached), 32'd1);
        check("wr_count", 32'(writes), 32'(exp_writes));
        check("wr_last_ram", 32'(ram[15'(16'h0200 + exp_writes - 1)]),
              32'(8'(8'h30 + exp_writes - 1)));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
